// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// control-bundle layout, per-stage payload widths and the main-entry source select.
package pipe_pkg;

   localparam int CTRL_W        = 6;
   localparam int CTRL_BRANCH   = 0;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_REGWRITE = 4;
   localparam int CTRL_ZERO     = 5;

   // PC + instruction; PC + rs1/rs2 data + imm + rd; PC + ALU + store data + rd; mem data + ALU + rd
   localparam int IFID_DATA_W  = 64 + 32;
   localparam int IDEX_DATA_W  = 64 + 64 + 64 + 64 + 5;
   localparam int EXMEM_DATA_W = 64 + 64 + 64 + 5;
   localparam int MEMWB_DATA_W = 64 + 64 + 5;

   typedef enum logic [1:0] {
      M_HOLD      = 2'd0,
      M_FROM_IN   = 2'd1,
      M_FROM_SKID = 2'd2
   } m_src_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] COUNT_MAX = {W{1'b1}};

   logic [W-1:0] count_r;

   // count qualifying cycles, sticking at the maximum
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != COUNT_MAX)) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional skid entry,
// flush for misprediction recovery, and saturating stall/bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = EXMEM_DATA_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              m_valid_r;
   logic [DATA_W-1:0] m_data_r;
   logic [CTRL_W-1:0] m_ctrl_r;
   logic              s_valid_r;
   logic [DATA_W-1:0] s_data_r;
   logic [CTRL_W-1:0] s_ctrl_r;
   logic              in_ready_r;

   logic              in_ready_s;
   logic              take_in_s;
   logic              take_out_s;
   logic              m_valid_nx_s;
   logic              s_valid_nx_s;
   logic              s_load_s;
   m_src_t            m_src_s;

   // with a skid entry, in_ready comes straight from a flop so out_ready never reaches it
   assign in_ready_s = (SKID != 0) ? in_ready_r : (!m_valid_r || out_ready);
   assign take_in_s  = in_valid && in_ready_s && !flush;
   assign take_out_s = m_valid_r && out_ready;

   // next-state selection for the main and skid entries
   always_comb begin
      m_valid_nx_s = m_valid_r;
      s_valid_nx_s = s_valid_r;
      m_src_s      = M_HOLD;
      s_load_s     = 1'b0;
      if (flush) begin
         m_valid_nx_s = 1'b0;
         s_valid_nx_s = 1'b0;
      end else if (SKID != 0) begin
         if (s_valid_r) begin
            if (take_out_s) begin
               m_src_s      = M_FROM_SKID;
               s_valid_nx_s = 1'b0;
            end else begin
               m_src_s = M_HOLD;
            end
         end else if (m_valid_r) begin
            if (take_in_s && take_out_s) begin
               m_src_s = M_FROM_IN;
            end else if (take_in_s) begin
               s_load_s     = 1'b1;
               s_valid_nx_s = 1'b1;
            end else if (take_out_s) begin
               m_valid_nx_s = 1'b0;
            end else begin
               m_src_s = M_HOLD;
            end
         end else begin
            if (take_in_s) begin
               m_src_s      = M_FROM_IN;
               m_valid_nx_s = 1'b1;
            end else begin
               m_src_s = M_HOLD;
            end
         end
      end else begin
         if (take_in_s) begin
            m_src_s      = M_FROM_IN;
            m_valid_nx_s = 1'b1;
         end else if (take_out_s) begin
            m_valid_nx_s = 1'b0;
         end else begin
            m_src_s = M_HOLD;
         end
      end
   end

   // entry storage; ctrl is cleared whenever M goes empty so bubbles present a NOP
   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid_r  <= 1'b0;
         m_data_r   <= {DATA_W{1'b0}};
         m_ctrl_r   <= {CTRL_W{1'b0}};
         s_valid_r  <= 1'b0;
         s_data_r   <= {DATA_W{1'b0}};
         s_ctrl_r   <= {CTRL_W{1'b0}};
         in_ready_r <= 1'b1;
      end else begin
         m_valid_r  <= m_valid_nx_s;
         s_valid_r  <= s_valid_nx_s;
         in_ready_r <= !s_valid_nx_s;
         case (m_src_s)
            M_FROM_IN: begin
               m_data_r <= in_data;
               m_ctrl_r <= in_ctrl;
            end
            M_FROM_SKID: begin
               m_data_r <= s_data_r;
               m_ctrl_r <= s_ctrl_r;
            end
            default: begin
               m_data_r <= m_data_r;
               m_ctrl_r <= m_valid_nx_s ? m_ctrl_r : {CTRL_W{1'b0}};
            end
         endcase
         if (s_load_s) begin
            s_data_r <= in_data;
            s_ctrl_r <= in_ctrl;
         end else begin
            s_data_r <= s_data_r;
            s_ctrl_r <= s_ctrl_r;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = m_valid_r;
   assign out_data  = m_data_r;
   assign out_ctrl  = m_ctrl_r;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (m_valid_r && !out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!m_valid_r),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a SKID=1 stage with 4-bit counters and a SKID=0 stage, both 16-bit payload.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
   logic [15:0] a_in_data, a_out_data;
   logic [5:0]  a_in_ctrl, a_out_ctrl;
   logic [3:0]  a_stall_cnt, a_bubble_cnt;

   logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
   logic [15:0] b_in_data, b_out_data;
   logic [5:0]  b_in_ctrl, b_out_ctrl;
   logic [15:0] b_stall_cnt, b_bubble_cnt;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(6), .SKID(1), .CNT_W(4)) u_skid (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
      .flush(a_flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
      .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(6), .SKID(0), .CNT_W(16)) u_noskid (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
      .flush(b_flush),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
      .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 16'hAAAA;
      a_in_ctrl   = 6'h3F;
      a_flush     = 1'b0;
      a_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = 16'hBBBB;
      b_in_ctrl   = 6'h3F;
      b_flush     = 1'b0;
      b_out_ready = 1'b1;

      // reset held two cycles with input offered
      tick();
      tick();
      chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
      chk("rst_out_ctrl", {26'd0, a_out_ctrl}, 32'd0);
      chk("rst_out_data", {16'd0, a_out_data}, 32'd0);
      chk("rst_stall", {28'd0, a_stall_cnt}, 32'd0);
      chk("rst_bubble", {28'd0, a_bubble_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
      chk("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
      chk("rst_b_in_ready", {31'd0, b_in_ready}, 32'd1);

      // stream 1..4 with out_ready=1
      reset      = 1'b0;
      b_in_valid = 1'b0;
      a_in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         a_in_data = 16'(i);
         a_in_ctrl = 6'(i);
         tick();
         chk("stream_valid", {31'd0, a_out_valid}, 32'd1);
         chk("stream_data", {16'd0, a_out_data}, 32'(i));
         chk("stream_ctrl", {26'd0, a_out_ctrl}, 32'(i));
         chk("stream_in_ready", {31'd0, a_in_ready}, 32'd1);
      end
      a_in_valid = 1'b0;
      tick();
      chk("stream_drained", {31'd0, a_out_valid}, 32'd0);
      chk("stream_nop_ctrl", {26'd0, a_out_ctrl}, 32'd0);
      chk("stream_stall", {28'd0, a_stall_cnt}, 32'd0);
      chk("stream_bubble", {28'd0, a_bubble_cnt}, 32'd1);

      // backpressure: A into M, B into S
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 16'h00A0;
      a_in_ctrl   = 6'h02;
      tick();
      chk("bp_a_data", {16'd0, a_out_data}, 32'h00A0);
      chk("bp_a_in_ready", {31'd0, a_in_ready}, 32'd1);
      a_in_data = 16'h00B0;
      a_in_ctrl = 6'h04;
      tick();
      chk("bp_s_full_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("bp_head_a", {16'd0, a_out_data}, 32'h00A0);
      a_in_data = 16'hDEAD;
      a_in_ctrl = 6'h3F;
      tick();
      chk("bp_hold_head", {16'd0, a_out_data}, 32'h00A0);
      chk("bp_hold_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("bp_stall", {28'd0, a_stall_cnt}, 32'd2);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      tick();
      chk("bp_head_b", {16'd0, a_out_data}, 32'h00B0);
      chk("bp_ctrl_b", {26'd0, a_out_ctrl}, 32'h04);
      chk("bp_in_ready_back", {31'd0, a_in_ready}, 32'd1);
      tick();
      chk("bp_empty", {31'd0, a_out_valid}, 32'd0);

      // flush with M and S full and an input offered
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 16'h0011;
      a_in_ctrl   = 6'h10;
      tick();
      a_in_data = 16'h0022;
      tick();
      chk("fl_full_in_ready", {31'd0, a_in_ready}, 32'd0);
      a_flush   = 1'b1;
      a_in_data = 16'h00CC;
      a_in_ctrl = 6'h3F;
      tick();
      chk("fl_out_valid", {31'd0, a_out_valid}, 32'd0);
      chk("fl_out_ctrl", {26'd0, a_out_ctrl}, 32'd0);
      chk("fl_in_ready", {31'd0, a_in_ready}, 32'd1);
      chk("fl_stall_kept", {28'd0, a_stall_cnt}, 32'd4);
      a_flush     = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      tick();
      chk("fl_no_c", {31'd0, a_out_valid}, 32'd0);
      chk("fl_bubble", {28'd0, a_bubble_cnt}, 32'd4);
      // flush discards an input even when in_ready=1
      a_flush    = 1'b1;
      a_in_valid = 1'b1;
      a_in_data  = 16'h00DD;
      tick();
      chk("fl_discard_ready", {31'd0, a_out_valid}, 32'd0);

      // stall counter saturation at 15
      a_flush     = 1'b0;
      a_in_data   = 16'h0055;
      a_in_ctrl   = 6'h01;
      a_out_ready = 1'b0;
      tick();
      a_in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      chk("sat_stall", {28'd0, a_stall_cnt}, 32'd15);
      chk("sat_head", {16'd0, a_out_data}, 32'h0055);
      a_out_ready = 1'b1;
      tick();
      chk("sat_stall_hold", {28'd0, a_stall_cnt}, 32'd15);
      chk("sat_drained", {31'd0, a_out_valid}, 32'd0);

      // SKID=0: combinational in_ready
      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      b_in_data   = 16'h0111;
      b_in_ctrl   = 6'h08;
      tick();
      chk("ns_valid", {31'd0, b_out_valid}, 32'd1);
      chk("ns_data", {16'd0, b_out_data}, 32'h0111);
      chk("ns_in_ready_low", {31'd0, b_in_ready}, 32'd0);
      tick();
      chk("ns_hold_data", {16'd0, b_out_data}, 32'h0111);
      chk("ns_stall", {16'd0, b_stall_cnt}, 32'd1);
      b_out_ready = 1'b1;
      b_in_data   = 16'h0222;
      b_in_ctrl   = 6'h10;
      #1;
      chk("ns_in_ready_same", {31'd0, b_in_ready}, 32'd1);
      tick();
      chk("ns_replace_data", {16'd0, b_out_data}, 32'h0222);
      chk("ns_replace_ctrl", {26'd0, b_out_ctrl}, 32'h10);
      chk("ns_replace_valid", {31'd0, b_out_valid}, 32'd1);
      b_in_valid = 1'b0;
      tick();
      chk("ns_empty", {31'd0, b_out_valid}, 32'd0);
      chk("ns_empty_ctrl", {26'd0, b_out_ctrl}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
